key_click_decoder: RTL and testbench
====================================

# key_click_decoder

Per-key click classifier placed directly downstream of the key debouncer. It consumes the debouncer's one-cycle press pulses and decides, per key, whether each burst of presses was a single click or a double click within a fixed time window. With the optional feature it also recognises triple clicks. Each result is emitted as a one-cycle registered strobe for the control logic that follows.

## Interface
Parameters:
- `N`, 1, number of keys; one independent channel per key.
- `WIN`, 3600000, click window in clock cycles (300 ms at 12 MHz); legal range 2 to 2^CW−1.
- `CW`, 22, window counter width; must satisfy 2^CW > WIN.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  reset. Asynchronous assertion, active-low.
- `key_pulse`  input  N  one-cycle-high press pulses from the debouncer; bit i belongs to key i.
- `single_click`  output  N  one-cycle strobe per key: single click decided.
- `double_click`  output  N  one-cycle strobe per key: double click decided.
- `triple_click`  output  N  one-cycle strobe per key: triple click decided. Constant 0 when the feature is compiled out.

## Operation
- Channels are fully independent. Each channel has its own state register and its own CW-bit counter. Events on different keys in the same cycle are all reported.
- Channel states: IDLE, WAIT1, WAIT2. WAIT2 exists only with `KEY_TRIPLE_CLICK_EN`.
- IDLE
  - `key_pulse[i]` = 1 → go to WAIT1, counter cleared to 0.
  - Otherwise stay in IDLE.
- WAIT1: counter increments by 1 each cycle.
  - `key_pulse[i]` = 1 → second press.
    - Without the feature: assert `double_click[i]`, go to IDLE.
    - With the feature: go to WAIT2, counter cleared to 0.
  - Else, when counter == WIN−1 → assert `single_click[i]`, go to IDLE.
- WAIT2 (feature only): counter increments by 1 each cycle.
  - `key_pulse[i]` = 1 → assert `triple_click[i]`, go to IDLE.
  - Else, when counter == WIN−1 → assert `double_click[i]`, go to IDLE.
- Precedence: a press pulse in the same cycle the counter reaches WIN−1 counts as a press; the timeout is ignored.
- The counter is held at 0 in IDLE. It never wraps, because the state is left at WIN−1.
- At most one of the three outputs is high per channel in any cycle. Every click burst produces exactly one strobe.
- Presses beyond the maximum count (2, or 3 with the feature) start a new burst from IDLE.

## Timing
- All outputs are registered. Each strobe is high for exactly one cycle, in the cycle after the deciding event (press pulse or timeout compare).
- The state is IDLE in the same cycle the strobe is high. A press pulse in that cycle opens a new burst: WAIT1 on the next cycle.
- Single-click latency: press at cycle t → WAIT1 from t+1 → counter reaches WIN−1 at t+WIN → `single_click` high at t+WIN+1.
- Double-click latency, feature off: second press at cycle u → `double_click` high at u+1.
- Maximum gap between presses that still counts as one burst: a press sampled while the counter is 0 to WIN−1, i.e. up to WIN cycles after the previous press.
- Reset values: all outputs 0, all states IDLE, all counters 0.
- Reset asserted mid-burst: the burst is abandoned and no strobe is produced, during or after reset.
- First clock edge after reset deassertion: the channel samples `key_pulse` normally.

## Configuration
- `KEY_TRIPLE_CLICK_EN`
  - Defined: WAIT2 state is present; triple-click detection is active; a double click is reported only after the WIN timeout following the second press.
  - Undefined: no WAIT2 state; `triple_click` is tied to 0; the double click is reported immediately at the second press (u+1).

## Test plan
Simulation uses N=2, WIN=16, CW=5.
- Single click: pulse on `key_pulse[0]` at cycle 10 → `single_click[0]` high only at cycle 27. No other strobes on either key.
- Double click at the boundary, feature off: pulses at 10 and 26 (counter at 15 = WIN−1 when sampled) → `double_click[0]` high at 27; `single_click[0]` never asserted.
- Gap one cycle too long: pulses at 10 and 27 → `single_click[0]` at 27, then `single_click[0]` again at 44.
- Independent keys: `key_pulse` = 2'b11 at cycle 5 → `single_click` = 2'b11 at cycle 22.
- Reset mid-burst: pulse at 10, `rst` low during cycles 15–17, no further pulses → all outputs stay 0 through cycle 60.
- Triple click, `KEY_TRIPLE_CLICK_EN` defined: pulses at 10, 14, 18 → `triple_click[0]` at 19. Pulses at 10, 14 only → `double_click[0]` at 31.

Source files
------------

// File: rtl/key_click_decoder.sv
// Per-key click classifier: turns debounced press pulses into single/double (and
// optional triple, enabled by define KEY_TRIPLE_CLICK_EN) click strobes.
module key_click_decoder #(
  parameter int N   = 1,
  parameter int WIN = 3600000,
  parameter int CW  = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key_pulse,
  output logic [N-1:0] single_click,
  output logic [N-1:0] double_click,
  output logic [N-1:0] triple_click
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef KEY_TRIPLE_CLICK_EN
    WAIT1 = 2'd1,
    WAIT2 = 2'd2
`else
    WAIT1 = 2'd1
`endif
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIN - 1);

  state_t        state_r     [N];
  state_t        state_nxt_s [N];
  logic [CW-1:0] cnt_r       [N];
  logic [CW-1:0] cnt_nxt_s   [N];
  logic [N-1:0]  single_r, single_nxt_s;
  logic [N-1:0]  double_r, double_nxt_s;
`ifdef KEY_TRIPLE_CLICK_EN
  logic [N-1:0]  triple_r, triple_nxt_s;
`endif

  // Next-state, counter and strobe decode for every channel; a press beats a timeout.
  always_comb begin
    single_nxt_s = {N{1'b0}};
    double_nxt_s = {N{1'b0}};
`ifdef KEY_TRIPLE_CLICK_EN
    triple_nxt_s = {N{1'b0}};
`endif
    for (int i = 0; i < N; i++) begin
      state_nxt_s[i] = state_r[i];
      cnt_nxt_s[i]   = {CW{1'b0}};
      case (state_r[i])
        IDLE: begin
          if (key_pulse[i]) begin
            state_nxt_s[i] = WAIT1;
          end else begin
            state_nxt_s[i] = IDLE;
          end
        end
        WAIT1: begin
          if (key_pulse[i]) begin
`ifdef KEY_TRIPLE_CLICK_EN
            state_nxt_s[i] = WAIT2;
`else
            double_nxt_s[i] = 1'b1;
            state_nxt_s[i]  = IDLE;
`endif
          end else if (cnt_r[i] == LAST) begin
            single_nxt_s[i] = 1'b1;
            state_nxt_s[i]  = IDLE;
          end else begin
            cnt_nxt_s[i] = cnt_r[i] + CW'(1);
          end
        end
`ifdef KEY_TRIPLE_CLICK_EN
        WAIT2: begin
          if (key_pulse[i]) begin
            triple_nxt_s[i] = 1'b1;
            state_nxt_s[i]  = IDLE;
          end else if (cnt_r[i] == LAST) begin
            double_nxt_s[i] = 1'b1;
            state_nxt_s[i]  = IDLE;
          end else begin
            cnt_nxt_s[i] = cnt_r[i] + CW'(1);
          end
        end
`endif
        default: begin
          state_nxt_s[i] = IDLE;
        end
      endcase
    end
  end

  // Channel state, counters and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        state_r[i] <= IDLE;
        cnt_r[i]   <= {CW{1'b0}};
      end
      single_r <= {N{1'b0}};
      double_r <= {N{1'b0}};
`ifdef KEY_TRIPLE_CLICK_EN
      triple_r <= {N{1'b0}};
`endif
    end else begin
      for (int i = 0; i < N; i++) begin
        state_r[i] <= state_nxt_s[i];
        cnt_r[i]   <= cnt_nxt_s[i];
      end
      single_r <= single_nxt_s;
      double_r <= double_nxt_s;
`ifdef KEY_TRIPLE_CLICK_EN
      triple_r <= triple_nxt_s;
`endif
    end
  end

  assign single_click = single_r;
  assign double_click = double_r;
`ifdef KEY_TRIPLE_CLICK_EN
  assign triple_click = triple_r;
`else
  assign triple_click = {N{1'b0}};
`endif

endmodule

// File: tb/tb_key_click_decoder.sv
// Scoreboard bench for key_click_decoder (N=2, WIN=16, CW=5); honours KEY_TRIPLE_CLICK_EN.
module tb_key_click_decoder;

  logic       clk;
  logic       rst;
  logic [1:0] key_pulse;
  logic [1:0] single_click;
  logic [1:0] double_click;
  logic [1:0] triple_click;

  key_click_decoder #(.N(2), .WIN(16), .CW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_pulse    (key_pulse),
    .single_click (single_click),
    .double_click (double_click),
    .triple_click (triple_click)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ev layout: [5:4] triple, [3:2] double, [1:0] single
  typedef struct packed {
    int         cyc;
    logic [1:0] k;
    int         ecyc;
    logic [5:0] ev;
  } stim_t;

  typedef struct packed {
    int         cyc;
    logic [5:0] v;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic add_stim(input int cyc, input logic [1:0] k, input int ecyc, input logic [5:0] ev);
    stim_t s;
    s.cyc = cyc; s.k = k; s.ecyc = ecyc; s.ev = ev;
    stim_q.push_back(s);
  endtask

  task automatic run_test(input string name, input int len, input int rst_lo, input int rst_hi);
    logic [5:0] ev;
    exp_t       e;
    exp_q.delete();
    key_pulse = 2'b00;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq({name, "_reset"}, {triple_click, double_click, single_click}, 6'b000000);
    rst = 1'b1;
    for (int c = 0; c <= len; c++) begin
      ev = 6'b000000;
      for (int j = exp_q.size() - 1; j >= 0; j--) begin
        if (exp_q[j].cyc == c) begin
          ev = ev | exp_q[j].v;
          exp_q.delete(j);
        end
      end
      check_eq($sformatf("%s@%0d", name, c), {triple_click, double_click, single_click}, ev);
      if (c == rst_lo) rst = 1'b0;
      if (c == rst_hi) rst = 1'b1;
      key_pulse = 2'b00;
      while (stim_q.size() > 0 && stim_q[0].cyc == c) begin
        key_pulse = key_pulse | stim_q[0].k;
        if (stim_q[0].ecyc >= 0) begin
          e.cyc = stim_q[0].ecyc;
          e.v   = stim_q[0].ev;
          exp_q.push_back(e);
        end
        void'(stim_q.pop_front());
      end
      @(negedge clk);
    end
    key_pulse = 2'b00;
    check_eq({name, "_drain"}, 6'(exp_q.size() + stim_q.size()), 6'd0);
    stim_q.delete();
  endtask

  initial begin
    rst = 1'b0;
    key_pulse = 2'b00;

    add_stim(10, 2'b01, 27, 6'b000001);
    run_test("single", 50, -1, -1);

    add_stim(10, 2'b01, -1, 6'b000000);
`ifdef KEY_TRIPLE_CLICK_EN
    add_stim(26, 2'b01, 43, 6'b000100);
`else
    add_stim(26, 2'b01, 27, 6'b000100);
`endif
    run_test("dbl_edge", 60, -1, -1);

    add_stim(10, 2'b01, 27, 6'b000001);
    add_stim(27, 2'b01, 44, 6'b000001);
    run_test("gap_long", 60, -1, -1);

    add_stim(5, 2'b11, 22, 6'b000011);
    run_test("indep", 40, -1, -1);

    add_stim(10, 2'b01, -1, 6'b000000);
    run_test("rst_mid", 60, 15, 18);

    add_stim(10, 2'b01, -1, 6'b000000);
`ifdef KEY_TRIPLE_CLICK_EN
    add_stim(14, 2'b01, -1, 6'b000000);
    add_stim(18, 2'b01, 19, 6'b010000);
`else
    add_stim(14, 2'b01, 15, 6'b000100);
    add_stim(18, 2'b01, 35, 6'b000001);
`endif
    run_test("three", 50, -1, -1);

`ifdef KEY_TRIPLE_CLICK_EN
    add_stim(10, 2'b01, -1, 6'b000000);
    add_stim(14, 2'b01, 31, 6'b000100);
    run_test("dbl_to", 45, -1, -1);
`endif

    add_stim(5, 2'b11, 22, 6'b000001);
`ifdef KEY_TRIPLE_CLICK_EN
    add_stim(8, 2'b10, 25, 6'b001000);
`else
    add_stim(8, 2'b10, 9, 6'b001000);
`endif
    run_test("mixed", 40, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
